// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 stride-2 pooling controller.
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVEN_ROW = 2'd1,
    ODD_ROW  = 2'd2,
    DRAIN    = 2'd3
  } pool_state_e;

  localparam int POOL_AVG = 0;
  localparam int POOL_MAX = 1;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_combine.sv
// Two-input signed combine: maximum for max pooling, full-width add for average pooling.
module pool_combine
  import pool_pkg::*;
#(
  parameter int W     = 10,
  parameter int PTYPE = POOL_MAX
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_y
);

  if (PTYPE == POOL_MAX) begin : g_max
    assign o_y = (i_a > i_b) ? i_a : i_b;
  end else begin : g_add
    assign o_y = i_a + i_b;
  end

endmodule

// File: rtl/pool2x2_ctrl.sv
// Streaming 2x2 stride-2 pooling controller: row-major pixels in, one pooled value per window out.
// Handshakes: a transfer happens on a rising edge where valid && ready; out_valid/out_data hold until accepted.
module pool2x2_ctrl
  import pool_pkg::*;
#(
  parameter int N     = 8,
  parameter int Q     = 4,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PTYPE = POOL_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [N-1:0]      in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output pool_state_e       o_dbg_state
);

  localparam int W   = N + 2;
  localparam int CW  = cnt_w(IMG_W);
  localparam int RW  = cnt_w(IMG_H);
  localparam int IW  = cnt_w(IMG_W / 2);
  localparam int LBD = 1 << IW;

  if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2 || Q >= N) begin : g_param_check
    $error("pool2x2_ctrl: image dimensions must be even and >= 2, and Q < N");
  end

  pool_state_e         r_state;
  pool_state_e         w_state_nxt;
  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic [N-1:0]        r_h;
  logic signed [W-1:0] r_line_buf [LBD];
  logic [N-1:0]        r_out_data;
  logic                r_out_valid;
  logic                r_done;

  logic                w_in_ready;
  logic                w_acc;
  logic                w_col_last;
  logic                w_row_last;
  logic                w_win;
  logic                w_done_nxt;
  logic [IW-1:0]       w_lb_idx;
  logic signed [W-1:0] w_h_ext;
  logic signed [W-1:0] w_px_ext;
  logic signed [W-1:0] w_pair;
  logic signed [W-1:0] w_quad;
  logic signed [W-1:0] w_res_full;
  logic [N-1:0]        w_result;
  logic                w_unused;

  assign w_in_ready = (r_state == EVEN_ROW || r_state == ODD_ROW) && (!r_out_valid || out_ready);
  assign w_acc      = in_valid && w_in_ready;
  assign w_col_last = (r_col == CW'(IMG_W - 1));
  assign w_row_last = (r_row == RW'(IMG_H - 1));
  assign w_win      = w_acc && (r_state == ODD_ROW) && r_col[0];
  assign w_lb_idx   = IW'(r_col >> 1);

  assign w_h_ext  = {{2{r_h[N-1]}}, r_h};
  assign w_px_ext = {{2{in_data[N-1]}}, in_data};

  pool_combine #(.W(W), .PTYPE(PTYPE)) u_pair (
    .i_a (w_h_ext),
    .i_b (w_px_ext),
    .o_y (w_pair)
  );

  pool_combine #(.W(W), .PTYPE(PTYPE)) u_merge (
    .i_a (r_line_buf[w_lb_idx]),
    .i_b (w_pair),
    .o_y (w_quad)
  );

  // Sum of four N-bit values fits in N+2 bits; the arithmetic shift floors the average.
  assign w_res_full = (PTYPE == POOL_MAX) ? w_quad : (w_quad >>> 2);
  assign w_result   = w_res_full[N-1:0];
  assign w_unused   = ^w_res_full[W-1:N];

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = EVEN_ROW;
      end
      EVEN_ROW: begin
        if (w_acc && w_col_last) w_state_nxt = ODD_ROW;
      end
      ODD_ROW: begin
        if (w_acc && w_col_last) w_state_nxt = w_row_last ? DRAIN : EVEN_ROW;
      end
      DRAIN: begin
        if (!r_out_valid || out_ready) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_h         <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (r_state == IDLE && start) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_acc) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (!r_col[0]) r_h <= in_data;
      end
      // A completing window takes priority; the held result was accepted this same cycle.
      if (w_win) begin
        r_out_data  <= w_result;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Line buffer holds horizontal partials across the row pair; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_acc && r_state == EVEN_ROW && r_col[0]) r_line_buf[w_lb_idx] <= w_pair;
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign in_ready    = w_in_ready;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign o_dbg_state = r_state;

endmodule
